// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : int_rs_types (package)
//  Purpose  : Shared CDB packet type, index widths and round-robin helper
//             for the integer reservation-station / CDB slice.
//  Revision : 1.0  initial release
// ============================================================================
package int_rs_types;

    localparam int ROB_IDX_W  = 5;
    localparam int PRF_IDX_W  = 6;
    localparam int ARCH_IDX_W = 5;
    localparam int XLEN       = 32;

    // One completed result as seen on the common data bus.
    typedef struct packed {
        logic [ROB_IDX_W-1:0]  rob_id;
        logic [ARCH_IDX_W-1:0] rd_arch;
        logic [PRF_IDX_W-1:0]  rd_phy;
        logic [XLEN-1:0]       rd_value;
        logic [XLEN-1:0]       rs1_value_dbg;
        logic [XLEN-1:0]       rs2_value_dbg;
    } cdb_pkt_t;

    // FU-side output register carries exactly the CDB payload.
    typedef cdb_pkt_t fu_cdb_reg_t;

    // Next round-robin start position after index idx among n requesters.
    function automatic int rr_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_if
//  Purpose  : FU-to-CDB handshake bundle: per-FU valid/ready/packet inputs
//             and the single registered CDB broadcast.
//  Revision : 1.0  initial release
// ============================================================================
interface cdb_arbiter_if #(
    parameter int N_FU = 4
);
    import int_rs_types::*;

    localparam int SRC_W = $clog2(N_FU);

    logic [N_FU-1:0]     fu_valid;
    logic [N_FU-1:0]     fu_ready;
    cdb_pkt_t [N_FU-1:0] fu_pkt;
    logic                cdb_valid;
    cdb_pkt_t            cdb_pkt;
    logic [SRC_W-1:0]    cdb_src;

    // Producer side: functional units plus CDB consumers.
    modport master (
        output fu_valid, fu_pkt,
        input  fu_ready, cdb_valid, cdb_pkt, cdb_src
    );

    // Arbiter side.
    modport slave (
        input  fu_valid, fu_pkt,
        output fu_ready, cdb_valid, cdb_pkt, cdb_src
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fu_result_fifo
//  Purpose  : Small per-FU result FIFO. Ready depends only on occupancy, so
//             a full FIFO refuses a write even while it is being drained.
//  Revision : 1.0  initial release
// ============================================================================
module fu_result_fifo
    import int_rs_types::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     flush_i,
    input  wire logic     enq_i,
    input  wire cdb_pkt_t enq_pkt_i,
    output logic          enq_ready_o,
    input  wire logic     deq_i,
    output logic          deq_valid_o,
    output cdb_pkt_t      deq_pkt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    cdb_pkt_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_enq, w_deq;

    assign enq_ready_o = ~rst & (count_q != CNT_W'(DEPTH));
    assign deq_valid_o = (count_q != '0);
    assign deq_pkt_o   = mem_q[rd_ptr_q];

    // A flush drops both the in-cycle write and any in-cycle read.
    assign w_enq = enq_i & enq_ready_o & ~flush_i;
    assign w_deq = deq_i & deq_valid_o & ~flush_i;

    // Occupancy is unchanged when a write and a read coincide.
    always_comb begin
        count_d = count_q;
        if (w_enq && !w_deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_enq && w_deq) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy decides what is live.
    always_ff @(posedge clk) begin
        if (w_enq) mem_q[wr_ptr_q] <= enq_pkt_i;
    end
endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Buffers FU results per producer and broadcasts one per cycle
//             on a registered CDB using round-robin priority.
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter
    import int_rs_types::*;
#(
    parameter int N_FU  = 4,
    parameter int DEPTH = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   flush_i,
    cdb_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(N_FU);

    logic [N_FU-1:0]  w_req, w_deq, w_ready;
    cdb_pkt_t         w_head [N_FU];
    logic             w_any;
    logic [SRC_W-1:0] w_win;

    logic             cdb_valid_q, cdb_valid_d;
    cdb_pkt_t         cdb_pkt_q, cdb_pkt_d;
    logic [SRC_W-1:0] cdb_src_q, cdb_src_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    generate
        for (genvar i = 0; i < N_FU; i++) begin : g_fifo
            fu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk         (clk),
                .rst         (rst),
                .flush_i     (flush_i),
                .enq_i       (bus.fu_valid[i]),
                .enq_pkt_i   (bus.fu_pkt[i]),
                .enq_ready_o (w_ready[i]),
                .deq_i       (w_deq[i]),
                .deq_valid_o (w_req[i]),
                .deq_pkt_o   (w_head[i])
            );
            assign w_deq[i] = w_any & ~flush_i & (w_win == SRC_W'(i));
        end
    endgenerate

    // Round-robin pick: first non-empty FIFO at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < N_FU; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_FU;
            if (!w_any && w_req[SRC_W'(idx)]) begin
                w_any = 1'b1;
                w_win = SRC_W'(idx);
            end
        end
    end

    // Broadcast next-state: packet and source hold when idle or flushed.
    always_comb begin
        cdb_valid_d = 1'b0;
        cdb_pkt_d   = cdb_pkt_q;
        cdb_src_d   = cdb_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (!flush_i && w_any) begin
            cdb_valid_d = 1'b1;
            cdb_pkt_d   = w_head[w_win];
            cdb_src_d   = w_win;
            rr_ptr_d    = SRC_W'(rr_inc(int'(w_win), N_FU));
        end
    end

    // CDB output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q <= 1'b0;
            cdb_pkt_q   <= '0;
            cdb_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_pkt_q   <= cdb_pkt_d;
            cdb_src_q   <= cdb_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.fu_ready  = w_ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_pkt   = cdb_pkt_q;
    assign bus.cdb_src   = cdb_src_q;
endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench: directed vector table, backpressure
//             sequence and random traffic against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;
    import int_rs_types::*;

    localparam int N = 4;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_FU(N)) bus ();

    cdb_arbiter #(.N_FU(N), .DEPTH(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per FU plus the round-robin start index.
    cdb_pkt_t   mq [N][$];
    int         m_rr;
    logic       m_cv;
    cdb_pkt_t   m_pkt;
    int         m_src;
    logic [N-1:0] m_rdy;

    typedef struct {
        logic         r;
        logic         f;
        logic [N-1:0] v;
        logic [31:0]  base;
        logic         ecv;
        int           esrc;
        logic [31:0]  ebase;
        logic [N-1:0] erdy;
    } vec_t;
    vec_t vt [$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic cdb_pkt_t mk_pkt(input int i, input logic [31:0] base);
        cdb_pkt_t p;
        p.rob_id        = ROB_IDX_W'(3 + i);
        p.rd_arch       = ARCH_IDX_W'(i);
        p.rd_phy        = PRF_IDX_W'(17 + i);
        p.rd_value      = base + 32'(i);
        p.rs1_value_dbg = ~base;
        p.rs2_value_dbg = base ^ 32'(i);
        return p;
    endfunction

    function automatic cdb_pkt_t rnd_pkt();
        cdb_pkt_t p;
        p.rob_id        = ROB_IDX_W'($urandom);
        p.rd_arch       = ARCH_IDX_W'($urandom);
        p.rd_phy        = PRF_IDX_W'($urandom);
        p.rd_value      = $urandom;
        p.rs1_value_dbg = $urandom;
        p.rs2_value_dbg = $urandom;
        return p;
    endfunction

    // Advance the model by one clock edge given the inputs for that edge.
    task automatic model_step(input logic r, input logic f, input logic [N-1:0] v,
                              input cdb_pkt_t [N-1:0] p);
        logic [N-1:0] rdy_pre;
        int w;
        if (r) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr = 0; m_cv = 1'b0; m_pkt = '0; m_src = 0;
        end else begin
            w = -1;
            for (int i = 0; i < N; i++) rdy_pre[i] = (mq[i].size() < D);
            for (int k = 0; k < N; k++)
                if (w < 0 && mq[(m_rr + k) % N].size() > 0) w = (m_rr + k) % N;
            if (f) begin
                for (int i = 0; i < N; i++) mq[i].delete();
                m_cv = 1'b0;
            end else begin
                if (w >= 0) begin
                    m_cv  = 1'b1;
                    m_pkt = mq[w].pop_front();
                    m_src = w;
                    m_rr  = (w + 1) % N;
                end else begin
                    m_cv = 1'b0;
                end
                for (int i = 0; i < N; i++)
                    if (v[i] && rdy_pre[i]) mq[i].push_back(p[i]);
            end
        end
        for (int i = 0; i < N; i++) m_rdy[i] = !r && (mq[i].size() < D);
    endtask

    // Drive one cycle, then compare every DUT output with the model.
    task automatic cycle(input logic r, input logic f, input logic [N-1:0] v,
                         input cdb_pkt_t [N-1:0] p);
        rst = r; flush = f;
        bus.fu_valid = v;
        bus.fu_pkt   = p;
        model_step(r, f, v, p);
        @(posedge clk);
        #1;
        chk("m_cdb_valid", 128'(bus.cdb_valid), 128'(m_cv));
        chk("m_cdb_pkt",   128'(bus.cdb_pkt),   128'(m_pkt));
        chk("m_cdb_src",   128'(bus.cdb_src),   128'(m_src));
        chk("m_fu_ready",  128'(bus.fu_ready),  128'(m_rdy));
    endtask

    task automatic add(input logic r, input logic f, input logic [N-1:0] v, input logic [31:0] base,
                       input logic ecv, input int esrc, input logic [31:0] ebase, input logic [N-1:0] erdy);
        vec_t e;
        e.r = r; e.f = f; e.v = v; e.base = base;
        e.ecv = ecv; e.esrc = esrc; e.ebase = ebase; e.erdy = erdy;
        vt.push_back(e);
    endtask

    initial begin
        cdb_pkt_t [N-1:0] p;
        cdb_pkt_t         exp_pkt;
        int   acc1;
        int   seq;
        logic seen_drop;
        logic done;

        bus.fu_valid = '0;
        bus.fu_pkt   = '0;

        //   rst  flush v        base          ecv  src ebase         rdy
        add(1'b1, 1'b0, 4'b0000, 32'h0,        1'b0, 0, 32'h0,        4'b0000);
        add(1'b1, 1'b1, 4'b1111, 32'h0,        1'b0, 0, 32'h0,        4'b0000);
        // all four FUs at once, twice, from rr_ptr=0
        add(1'b0, 1'b0, 4'b1111, 32'h10,       1'b0, 0, 32'h0,        4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 0, 32'h10,       4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 1, 32'h10,       4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 2, 32'h10,       4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 3, 32'h10,       4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 0, 32'h0,        4'b1111);
        add(1'b0, 1'b0, 4'b1111, 32'h10,       1'b0, 0, 32'h0,        4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 0, 32'h10,       4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 1, 32'h10,       4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 2, 32'h10,       4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 3, 32'h10,       4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 0, 32'h0,        4'b1111);
        // single FU, two-edge latency, one-cycle pulse
        add(1'b0, 1'b0, 4'b0001, 32'hDEADBEEF, 1'b0, 0, 32'h0,        4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 0, 32'hDEADBEEF, 4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 0, 32'h0,        4'b1111);
        // FU2 full while being granted: no write that cycle (rr_ptr=1 here)
        add(1'b0, 1'b0, 4'b0111, 32'h100,      1'b0, 0, 32'h0,        4'b1111);
        add(1'b0, 1'b0, 4'b0100, 32'h200,      1'b1, 1, 32'h100,      4'b1011);
        add(1'b0, 1'b0, 4'b0100, 32'h300,      1'b1, 2, 32'h100,      4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 0, 32'h100,      4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 2, 32'h200,      4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 0, 32'h0,        4'b1111);
        // flush with FU0 x2 + FU3 x1 buffered and a new FU1 result
        add(1'b0, 1'b0, 4'b1001, 32'h400,      1'b0, 0, 32'h0,        4'b1111);
        add(1'b0, 1'b0, 4'b1001, 32'h500,      1'b1, 3, 32'h400,      4'b1110);
        add(1'b0, 1'b1, 4'b0010, 32'h600,      1'b0, 0, 32'h0,        4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 0, 32'h0,        4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 0, 32'h0,        4'b1111);
        // reset mid-stream, then restart from rr_ptr=0
        add(1'b0, 1'b0, 4'b1111, 32'h700,      1'b0, 0, 32'h0,        4'b1111);
        add(1'b0, 1'b0, 4'b1111, 32'h800,      1'b1, 0, 32'h700,      4'b0001);
        add(1'b1, 1'b0, 4'b0000, 32'h0,        1'b0, 0, 32'h0,        4'b0000);
        add(1'b0, 1'b0, 4'b1010, 32'h900,      1'b0, 0, 32'h0,        4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 1, 32'h900,      4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 3, 32'h900,      4'b1111);
        add(1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 0, 32'h0,        4'b1111);

        foreach (vt[k]) begin
            for (int i = 0; i < N; i++) p[i] = mk_pkt(i, vt[k].base);
            cycle(vt[k].r, vt[k].f, vt[k].v, p);
            chk("tbl_valid", 128'(bus.cdb_valid), 128'(vt[k].ecv));
            chk("tbl_ready", 128'(bus.fu_ready),  128'(vt[k].erdy));
            if (vt[k].r || vt[k].ecv) begin
                exp_pkt = vt[k].r ? cdb_pkt_t'('0) : mk_pkt(vt[k].esrc, vt[k].ebase);
                chk("tbl_src", 128'(bus.cdb_src), 128'(vt[k].r ? 0 : vt[k].esrc));
                chk("tbl_pkt", 128'(bus.cdb_pkt), 128'(exp_pkt));
            end
        end

        // Backpressure: FU1 streams 6 results while FU0/FU2 stay busy.
        acc1 = 0; seq = 0; seen_drop = 1'b0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            for (int i = 0; i < N; i++) p[i] = rnd_pkt();
            p[1].rd_value = 32'hB00 + 32'(acc1);
            if (m_rdy[1] && acc1 < 6) acc1++;
            cycle(1'b0, 1'b0, {1'b0, c < 12, seq < 6, c < 12}, p);
            seq = acc1;
            if (!bus.fu_ready[1]) seen_drop = 1'b1;
            done = (acc1 == 6) && (c >= 12) &&
                   (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() == 0);
        end
        chk("bp_fu1_all_accepted", 128'(acc1), 128'(6));
        chk("bp_ready1_dropped", 128'(seen_drop), 128'(1'b1));
        chk("bp_drained", 128'(done), 128'(1'b1));

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) p[i] = rnd_pkt();
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                  N'($urandom), p);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
